fifo_stream_drain: RTL and testbench

- Read-side stage directly downstream of the team's synchronous FIFO.
- Pops words from the FIFO (fifo_re, fifo_rd, fifo_empt) and presents them on a valid/ready stream master.
- Absorbs the FIFO's optional one-cycle output delay and isolates the FIFO pop from downstream backpressure timing: fifo_re never depends combinationally on m_rdy.
- Sustains one word per cycle when downstream is always ready.

---
 rtl/fifo_stream_drain.sv | 86 ++++++++
 tb/tb_fifo_stream_drain.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain.sv
// Read-side drain stage for the synchronous FIFO: pops words into a small skid
// buffer and presents them on a valid/ready stream master, hiding FIFO read latency.
module fifo_stream_drain #(
  parameter  int DATA_W = 32,
  parameter  int RD_DLY = 0,
  localparam int BUF_D  = 2 + RD_DLY,
  localparam int CNT_W  = $clog2(BUF_D + 1),
  localparam int PTR_W  = $clog2(BUF_D)
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              fifo_re,
  input  logic [DATA_W-1:0] fifo_rd,
  input  logic              fifo_empt,
  input  logic              flush,
  output logic              m_vld,
  input  logic              m_rdy,
  output logic [DATA_W-1:0] m_dat,
  output logic [CNT_W-1:0]  buf_cnt,
  output logic              udf_err
);

  logic [DATA_W-1:0] r_buf [BUF_D];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_inflight;
  logic              r_udf;

  logic [CNT_W:0]    w_occ;
  logic              w_cap;
  logic              w_xfer;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Buffered words plus the one possibly still on its way out of the FIFO.
  assign w_occ = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_inflight};

  // Pop decision uses only registered occupancy, never m_rdy, so the FIFO read
  // strobe is isolated from downstream backpressure timing.
  assign fifo_re = rstn & ~fifo_empt & ~flush & (w_occ < (CNT_W + 1)'(BUF_D));

  assign w_cap   = (RD_DLY == 0) ? fifo_re : r_inflight;
  assign m_vld   = (r_cnt != '0);
  assign w_xfer  = m_vld & m_rdy;
  assign m_dat   = r_buf[r_head];
  assign buf_cnt = r_cnt;
  assign udf_err = r_udf;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_udf      <= 1'b0;
    end else if (flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= (RD_DLY != 0) & fifo_re;
      if (fifo_re && fifo_empt) r_udf <= 1'b1;
      if (w_cap)  r_tail <= ptr_inc(r_tail);
      if (w_xfer) r_head <= ptr_inc(r_head);
      case ({w_cap, w_xfer})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // NOTE: the storage is reset deliberately so m_dat reads 0 during and right after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_D; i++) r_buf[i] <= '0;
    end else if (w_cap && !flush) begin
      r_buf[r_tail] <= fifo_rd;
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: drives an RD_DLY=0 and an RD_DLY=1 instance side by side
// from one upstream FIFO model and checks both against an occupancy/order scoreboard.
module tb_fifo_stream_drain;

  localparam int DW = 32;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic          flush = 1'b0;
  logic          m_rdy = 1'b0;
  logic          re0, re1, vld0, vld1, udf0, udf1;
  logic [DW-1:0] dat0, dat1;
  logic [DW-1:0] rd0   = '0;
  logic [DW-1:0] rd1   = '0;
  logic          empt0 = 1'b1;
  logic          empt1 = 1'b1;
  logic [1:0]    cnt0, cnt1;

  fifo_stream_drain #(.DATA_W(DW), .RD_DLY(0)) dut0 (
    .clk(clk), .rstn(rstn), .fifo_re(re0), .fifo_rd(rd0), .fifo_empt(empt0),
    .flush(flush), .m_vld(vld0), .m_rdy(m_rdy), .m_dat(dat0), .buf_cnt(cnt0),
    .udf_err(udf0)
  );

  fifo_stream_drain #(.DATA_W(DW), .RD_DLY(1)) dut1 (
    .clk(clk), .rstn(rstn), .fifo_re(re1), .fifo_rd(rd1), .fifo_empt(empt1),
    .flush(flush), .m_vld(vld1), .m_rdy(m_rdy), .m_dat(dat1), .buf_cnt(cnt1),
    .udf_err(udf1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Every word ever pushed, in push order; this is also the expected output stream.
  logic [DW-1:0] push_mem [4096];
  int            push_wr = 0;
  int            push_rd = 0;
  logic [DW-1:0] fq0 [$];
  logic [DW-1:0] fq1 [$];
  logic [DW-1:0] drop;

  // Upstream FIFO contents as seen by each instance (same pushes, own pops).
  always @(posedge clk) begin
    if (!rstn || flush) begin
      fq0.delete();
      fq1.delete();
      push_rd = push_wr;
      rd1 <= '0;
    end else begin
      if (re0 && fq0.size() > 0) drop = fq0.pop_front();
      if (re1 && fq1.size() > 0) rd1 <= fq1.pop_front();
      while (push_rd < push_wr) begin
        fq0.push_back(push_mem[push_rd]);
        fq1.push_back(push_mem[push_rd]);
        push_rd++;
      end
    end
    empt0 <= (fq0.size() == 0);
    rd0   <= (fq0.size() > 0) ? fq0[0] : '0;
    empt1 <= (fq1.size() == 0);
  end

  // Reference state: words held per instance, next expected word index, hold tracking.
  int            occ0 = 0, occ1 = 0, infl1 = 0;
  int            exp0 = 0, exp1 = 0;
  logic          hold0 = 1'b0, hold1 = 1'b0;
  logic [DW-1:0] hdat0, hdat1;

  task automatic push_word(input logic [DW-1:0] w);
    push_mem[push_wr] = w;
    push_wr++;
  endtask

  task automatic monitor();
    logic exp_re;
    logic xfer;
    if (!rstn) begin
      occ0 = 0; occ1 = 0; infl1 = 0;
      exp0 = push_wr; exp1 = push_wr;
      hold0 = 1'b0; hold1 = 1'b0;
      return;
    end
    exp_re = !empt0 && !flush && (occ0 < 2);
    n_cmp++;
    if ({vld0, cnt0, re0, udf0} !== {occ0 != 0, 2'(occ0), exp_re, 1'b0}) begin
      n_err++;
      $display("FAIL mon0_ctrl: vld/cnt/re/udf got %b/%0d/%b/%b want %b/%0d/%b/0",
               vld0, cnt0, re0, udf0, occ0 != 0, occ0, exp_re);
    end
    if (hold0) begin
      n_cmp++;
      if (vld0 !== 1'b1 || dat0 !== hdat0) begin
        n_err++;
        $display("FAIL mon0_hold: vld/dat got %b/%h want 1/%h", vld0, dat0, hdat0);
      end
    end
    if (flush) begin
      occ0 = 0; exp0 = push_wr; hold0 = 1'b0;
    end else begin
      xfer = vld0 && m_rdy;
      if (xfer) begin
        n_cmp++;
        if (exp0 >= push_wr) begin
          n_err++;
          $display("FAIL mon0_extra: unexpected word %h", dat0);
        end else if (dat0 !== push_mem[exp0]) begin
          n_err++;
          $display("FAIL mon0_order: word #%0d got %h want %h", exp0, dat0, push_mem[exp0]);
        end
        exp0++;
      end
      occ0  = occ0 + int'(re0) - int'(xfer);
      hold0 = vld0 && !m_rdy;
      hdat0 = dat0;
    end

    exp_re = !empt1 && !flush && (occ1 + infl1 < 3);
    n_cmp++;
    if ({vld1, cnt1, re1, udf1} !== {occ1 != 0, 2'(occ1), exp_re, 1'b0}) begin
      n_err++;
      $display("FAIL mon1_ctrl: vld/cnt/re/udf got %b/%0d/%b/%b want %b/%0d/%b/0",
               vld1, cnt1, re1, udf1, occ1 != 0, occ1, exp_re);
    end
    if (hold1) begin
      n_cmp++;
      if (vld1 !== 1'b1 || dat1 !== hdat1) begin
        n_err++;
        $display("FAIL mon1_hold: vld/dat got %b/%h want 1/%h", vld1, dat1, hdat1);
      end
    end
    if (flush) begin
      occ1 = 0; infl1 = 0; exp1 = push_wr; hold1 = 1'b0;
    end else begin
      xfer = vld1 && m_rdy;
      if (xfer) begin
        n_cmp++;
        if (exp1 >= push_wr) begin
          n_err++;
          $display("FAIL mon1_extra: unexpected word %h", dat1);
        end else if (dat1 !== push_mem[exp1]) begin
          n_err++;
          $display("FAIL mon1_order: word #%0d got %h want %h", exp1, dat1, push_mem[exp1]);
        end
        exp1++;
      end
      occ1  = occ1 + infl1 - int'(xfer);
      infl1 = int'(re1);
      hold1 = vld1 && !m_rdy;
      hdat1 = dat1;
    end
  endtask

  // One clock cycle: check at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    m_rdy = 1'b1;
    for (int k = 0; k < 3000 && !done; k++) begin
      if (exp0 == push_wr && exp1 == push_wr && vld0 === 1'b0 && vld1 === 1'b0) done = 1'b1;
      else step();
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain: undelivered d0=%0d d1=%0d of %0d", push_wr - exp0, push_wr - exp1, push_wr);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; m_rdy = 1'b0; flush = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({re0, vld0, cnt0, dat0, udf0, re1, vld1, cnt1, dat1, udf1} !== '0) begin
      n_err++;
      $display("FAIL reset_state: re/vld/cnt/dat/udf d0 %b/%b/%0d/%h/%b d1 %b/%b/%0d/%h/%b want all 0",
               re0, vld0, cnt0, dat0, udf0, re1, vld1, cnt1, dat1, udf1);
    end
    rstn = 1'b1;
    step();
    n_cmp++;
    if ({re0, vld0, re1, vld1} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_idle: re0/vld0/re1/vld1 got %b%b%b%b want 0000", re0, vld0, re1, vld1);
    end
  endtask

  task automatic test_burst3();
    logic [DW-1:0] w [3];
    logic          ev;
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
    m_rdy = 1'b1;
    for (int k = 0; k < 3; k++) push_word(w[k]);
    step();
    for (int i = 0; i < 6; i++) begin
      ev = (i >= 1 && i <= 3);
      n_cmp++;
      if (vld0 !== ev || re0 !== (i <= 2) || cnt0 > 2'd1 || (ev && dat0 !== w[(i + 2) % 3])) begin
        n_err++;
        $display("FAIL burst3_d0 cyc %0d: vld/re/cnt/dat got %b/%b/%0d/%h want %b/%b/<=1/%h",
                 i, vld0, re0, cnt0, dat0, ev, i <= 2, w[(i + 2) % 3]);
      end
      ev = (i >= 2 && i <= 4);
      n_cmp++;
      if (vld1 !== ev || re1 !== (i <= 2) || (ev && dat1 !== w[(i + 1) % 3])) begin
        n_err++;
        $display("FAIL burst3_d1 cyc %0d: vld/re/dat got %b/%b/%h want %b/%b/%h",
                 i, vld1, re1, dat1, ev, i <= 2, w[(i + 1) % 3]);
      end
      step();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic ev;
    m_rdy = 1'b1;
    for (int k = 0; k < 8; k++) push_word(DW'(k));
    step();
    for (int i = 0; i < 12; i++) begin
      ev = (i >= 2 && i <= 9);
      n_cmp++;
      if (vld1 !== ev || re1 !== (i <= 7) || (ev && dat1 !== DW'(i - 2))) begin
        n_err++;
        $display("FAIL b2b_d1 cyc %0d: vld/re/dat got %b/%b/%h want %b/%b/%h",
                 i, vld1, re1, dat1, ev, i <= 7, i - 2);
      end
      ev = (i >= 1 && i <= 8);
      n_cmp++;
      if (vld0 !== ev || re0 !== (i <= 7) || (ev && dat0 !== DW'(i - 1))) begin
        n_err++;
        $display("FAIL b2b_d0 cyc %0d: vld/re/dat got %b/%b/%h want %b/%b/%h",
                 i, vld0, re0, dat0, ev, i <= 7, i - 1);
      end
      step();
    end
    drain();
  endtask

  task automatic test_backpressure();
    m_rdy = 1'b0;
    for (int k = 0; k < 6; k++) push_word(32'h100 + DW'(k));
    repeat (7) step();
    n_cmp++;
    if ({vld0, re0, cnt0, dat0} !== {1'b1, 1'b0, 2'd2, 32'h100}) begin
      n_err++;
      $display("FAIL bp_d0: vld/re/cnt/dat got %b/%b/%0d/%h want 1/0/2/100", vld0, re0, cnt0, dat0);
    end
    n_cmp++;
    if ({vld1, re1, cnt1, dat1} !== {1'b1, 1'b0, 2'd3, 32'h100}) begin
      n_err++;
      $display("FAIL bp_d1: vld/re/cnt/dat got %b/%b/%0d/%h want 1/0/3/100", vld1, re1, cnt1, dat1);
    end
    drain();
  endtask

  task automatic test_random();
    int   sent = 0;
    logic r0, r1;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      m_rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        push_word($urandom);
        sent++;
      end
      r0 = re0; r1 = re1;
      m_rdy = ~m_rdy;
      #1;
      n_cmp++;
      if (re0 !== r0 || re1 !== r1) begin
        n_err++;
        $display("FAIL re_vs_rdy: re0/re1 got %b/%b want %b/%b after m_rdy toggle", re0, re1, r0, r1);
      end
      m_rdy = ~m_rdy;
      step();
    end
    drain();
    n_cmp++;
    if ({udf0, udf1} !== 2'b00) begin
      n_err++;
      $display("FAIL random_udf: udf0/udf1 got %b/%b want 0/0", udf0, udf1);
    end
  endtask

  task automatic test_flush();
    m_rdy = 1'b0;
    for (int k = 0; k < 4; k++) push_word(32'h200 + DW'(k));
    repeat (4) step();
    n_cmp++;
    if ({cnt0, re0, cnt1, re1, vld1} !== {2'd2, 1'b0, 2'd2, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL flush_pre: cnt0/re0/cnt1/re1/vld1 got %0d/%b/%0d/%b/%b want 2/0/2/0/1",
               cnt0, re0, cnt1, re1, vld1);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if ({vld0, cnt0, vld1, cnt1} !== 6'b0) begin
      n_err++;
      $display("FAIL flush_clear: vld0/cnt0/vld1/cnt1 got %b/%0d/%b/%0d want 0/0/0/0", vld0, cnt0, vld1, cnt1);
    end
    push_word(32'h2f0);
    push_word(32'h2f1);
    step();
    n_cmp++;
    if ({re0, re1} !== 2'b11) begin
      n_err++;
      $display("FAIL flush_pop_pre: re0/re1 got %b/%b want 1/1", re0, re1);
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if ({re0, re1} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_pop_block: re0/re1 got %b/%b want 0/0", re0, re1);
    end
    step();
    flush = 1'b0;
    n_cmp++;
    if ({vld0, cnt0, vld1, cnt1} !== 6'b0) begin
      n_err++;
      $display("FAIL flush2_clear: vld0/cnt0/vld1/cnt1 got %b/%0d/%b/%0d want 0/0/0/0", vld0, cnt0, vld1, cnt1);
    end
    m_rdy = 1'b1;
    for (int k = 0; k < 3; k++) push_word(32'h300 + DW'(k));
    step();
    step();
    n_cmp++;
    if ({vld0, dat0} !== {1'b1, 32'h300}) begin
      n_err++;
      $display("FAIL flush_first_d0: vld/dat got %b/%h want 1/300", vld0, dat0);
    end
    step();
    n_cmp++;
    if ({vld1, dat1} !== {1'b1, 32'h300}) begin
      n_err++;
      $display("FAIL flush_first_d1: vld/dat got %b/%h want 1/300", vld1, dat1);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    m_rdy = 1'b1;
    for (int k = 0; k < 8; k++) push_word(32'h400 + DW'(k));
    repeat (4) step();
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({vld0, re0, cnt0, dat0} !== '0) begin
      n_err++;
      $display("FAIL rst_async_d0: vld/re/cnt/dat got %b/%b/%0d/%h want 0/0/0/0", vld0, re0, cnt0, dat0);
    end
    n_cmp++;
    if ({vld1, re1, cnt1, dat1} !== '0) begin
      n_err++;
      $display("FAIL rst_async_d1: vld/re/cnt/dat got %b/%b/%0d/%h want 0/0/0/0", vld1, re1, cnt1, dat1);
    end
    repeat (2) step();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) push_word(32'h500 + DW'(k));
    drain();
    n_cmp++;
    if ({udf0, udf1} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_resume_udf: udf0/udf1 got %b/%b want 0/0", udf0, udf1);
    end
  endtask

  initial begin
    test_reset();
    test_burst3();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
